// File: rtl/text_renderer.sv
// Character-cell pixel generator: text buffer + palette + external font ROM
// to a fixed 4-edge-latency colour pair per clock, with no stalls or backpressure.
module text_renderer #(
  parameter int COLS       = 120,
  parameter int ROWS       = 37,
  parameter int XW         = 12,
  parameter int YW         = 12,
  parameter int GLYPH_W    = 8,
  parameter int GLYPH_H    = 16,
  parameter int SY_LOG2    = 1,
  parameter int CHAR_W     = 7,
  parameter int BLINK_LOG2 = 24,
  localparam int CELLS     = COLS * ROWS,
  localparam int AW        = $clog2(CELLS),
  localparam int CCW       = $clog2(COLS),
  localparam int CRW       = $clog2(ROWS),
  localparam int GWL       = $clog2(GLYPH_W),
  localparam int GHL       = $clog2(GLYPH_H),
  localparam int DW        = CHAR_W + 8,
  localparam int FAW       = CHAR_W + GHL
) (
  input  logic               i_clk,
  input  logic               i_resetn,
  input  logic [XW-1:0]      x,
  input  logic [YW-1:0]      y,
  input  logic               i_de,
  input  logic               i_wr_en,
  input  logic [AW-1:0]      i_wr_addr,
  input  logic [DW-1:0]      i_wr_data,
  input  logic               i_pal_wr_en,
  input  logic [3:0]         i_pal_idx,
  input  logic [23:0]        i_pal_data,
  input  logic               i_cur_en,
  input  logic [CCW-1:0]     i_cur_col,
  input  logic [CRW-1:0]     i_cur_row,
  output logic [FAW-1:0]     o_font_addr,
  input  logic [GLYPH_W-1:0] i_font_row,
  output logic [23:0]        o_color,
  output logic [23:0]        o_color_even,
  output logic               o_de
);

  localparam int PXW  = XW + 1;
  localparam int COLW = PXW - GWL;
  localparam int LYW  = YW - SY_LOG2;
  localparam int ROWW = LYW - GHL;

  logic [BLINK_LOG2:0] blink_cnt;
  logic [23:0]         pal [16];
  logic [DW-1:0]       mem [CELLS];

  // S1 combinational decode of the incoming pixel pair
  logic [PXW-1:0]  px;
  logic [COLW-1:0] cell_col;
  logic [ROWW-1:0] cell_row;
  logic [LYW-1:0]  line;
  logic [GWL-1:0]  pix_bit;
  logic [GHL-1:0]  glyph_row;
  logic [AW-1:0]   ram_addr;
  logic            border;
  logic            cur_hit;
  logic            wr_ok;

  always_comb begin
    px        = {x, 1'b0};
    cell_col  = COLW'(px >> GWL);
    pix_bit   = px[GWL-1:0];
    line      = LYW'(y >> SY_LOG2);
    glyph_row = line[GHL-1:0];
    cell_row  = ROWW'(line >> GHL);
    border    = (32'(cell_col) >= COLS) || (32'(cell_row) >= ROWS);
    cur_hit   = i_cur_en && blink_cnt[BLINK_LOG2] &&
                (32'(cell_col) == 32'(i_cur_col)) &&
                (32'(cell_row) == 32'(i_cur_row));
    ram_addr  = AW'(32'(cell_row) * COLS + 32'(cell_col));
    wr_ok     = i_wr_en && (32'(i_wr_addr) < CELLS);
  end

  logic           s1_de, s1_border, s1_cur, s1_rd;
  logic [GWL-1:0] s1_bit;
  logic [GHL-1:0] s1_grow;
  logic [AW-1:0]  s1_addr;

  logic           s2_de, s2_border, s2_cur;
  logic [GWL-1:0] s2_bit;
  logic [GHL-1:0] s2_grow;
  logic [DW-1:0]  ram_q;

  logic           s3_de, s3_border, s3_cur;
  logic [GWL-1:0] s3_bit;
  logic [3:0]     s3_fg, s3_bg;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      blink_cnt <= '0;
      s1_de     <= 1'b0;
      s1_border <= 1'b0;
      s1_cur    <= 1'b0;
      s1_rd     <= 1'b0;
      s1_bit    <= '0;
      s1_grow   <= '0;
      s1_addr   <= '0;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
      s1_de     <= i_de;
      s1_border <= border;
      s1_cur    <= cur_hit;
      s1_rd     <= i_de && !border;
      s1_bit    <= pix_bit;
      s1_grow   <= glyph_row;
      s1_addr   <= ram_addr;
    end
  end

  // Write port has no reset; the read register below sees pre-write data on collision.
  always_ff @(posedge i_clk) begin
    if (wr_ok) mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      ram_q     <= '0;
      s2_de     <= 1'b0;
      s2_border <= 1'b0;
      s2_cur    <= 1'b0;
      s2_bit    <= '0;
      s2_grow   <= '0;
    end else begin
      if (s1_rd) ram_q <= mem[s1_addr];
      s2_de     <= s1_de;
      s2_border <= s1_border;
      s2_cur    <= s1_cur;
      s2_bit    <= s1_bit;
      s2_grow   <= s1_grow;
    end
  end

  assign o_font_addr = {ram_q[CHAR_W-1:0], s2_grow};

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      s3_de     <= 1'b0;
      s3_border <= 1'b0;
      s3_cur    <= 1'b0;
      s3_bit    <= '0;
      s3_fg     <= '0;
      s3_bg     <= '0;
    end else begin
      s3_de     <= s2_de;
      s3_border <= s2_border;
      s3_cur    <= s2_cur;
      s3_bit    <= s2_bit;
      s3_fg     <= ram_q[CHAR_W+7:CHAR_W+4];
      s3_bg     <= ram_q[CHAR_W+3:CHAR_W];
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      for (int i = 0; i < 15; i++) pal[i] <= '0;
      pal[15] <= 24'hFFFFFF;
    end else if (i_pal_wr_en) begin
      pal[i_pal_idx] <= i_pal_data;
    end
  end

  // S4: font bit select (MSB = leftmost pixel), cursor swap, palette, gating
  logic [GWL-1:0] idx_l, idx_r;
  logic [3:0]     fg_sel, bg_sel;
  logic [23:0]    pix_l, pix_r;

  always_comb begin
    fg_sel = s3_fg;
    bg_sel = s3_bg;
    if (s3_cur) begin
      fg_sel = s3_bg;
      bg_sel = s3_fg;
    end
    idx_l = GWL'(GLYPH_W - 1) - s3_bit;
    idx_r = idx_l - GWL'(1);
    pix_l = i_font_row[idx_l] ? pal[fg_sel] : pal[bg_sel];
    pix_r = i_font_row[idx_r] ? pal[fg_sel] : pal[bg_sel];
    if (s3_border) begin
      pix_l = pal[0];
      pix_r = pal[0];
    end
    if (!s3_de) begin
      pix_l = '0;
      pix_r = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      o_color      <= '0;
      o_color_even <= '0;
      o_de         <= 1'b0;
    end else begin
      o_color      <= pix_l;
      o_color_even <= pix_r;
      o_de         <= s3_de;
    end
  end

endmodule

// File: tb/tb_text_renderer.sv
// Directed bench for text_renderer: default geometry, 3-bit blink for short cursor runs.
module tb_text_renderer;

  logic        clk = 1'b0;
  logic        resetn;
  logic [11:0] x, y;
  logic        de;
  logic        wr_en;
  logic [12:0] wr_addr;
  logic [14:0] wr_data;
  logic        pal_wr_en;
  logic [3:0]  pal_idx;
  logic [23:0] pal_data;
  logic        cur_en;
  logic [6:0]  cur_col;
  logic [5:0]  cur_row;
  logic [10:0] font_addr;
  logic [7:0]  font_row = 8'h00;
  logic [23:0] color_l, color_r;
  logic        de_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [15:0] step_id = '0;
  logic [64:0] exp_q[$];

  text_renderer #(.BLINK_LOG2(3)) dut (
    .i_clk(clk), .i_resetn(resetn), .x(x), .y(y), .i_de(de),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_pal_wr_en(pal_wr_en), .i_pal_idx(pal_idx), .i_pal_data(pal_data),
    .i_cur_en(cur_en), .i_cur_col(cur_col), .i_cur_row(cur_row),
    .o_font_addr(font_addr), .i_font_row(font_row),
    .o_color(color_l), .o_color_even(color_r), .o_de(de_out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom(input logic [10:0] a);
    case (a)
      11'h410: rom = 8'b1000_0001;
      11'h411: rom = 8'b0110_0000;
      11'h550: rom = 8'b1100_0000;
      default: rom = 8'h00;
    endcase
  endfunction

  always @(posedge clk) font_row <= rom(font_addr);

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: queue the expectation for this sample, check the one from 3 edges back
  task automatic cyc_step(input logic de_e, input logic [23:0] l, input logic [23:0] r);
    logic [64:0] e;
    exp_q.push_back({step_id, de_e, l, r});
    step_id++;
    @(posedge clk);
    #1;
    cyc++;
    if (exp_q.size() == 4) begin
      e = exp_q.pop_front();
      total++;
      assert ({de_out, color_l, color_r} === e[48:0]) else begin
        bad++;
        $error("FAIL pix step=%0d got de=%0b l=%h r=%h exp de=%0b l=%h r=%h",
               e[64:49], de_out, color_l, color_r, e[48], e[47:24], e[23:0]);
      end
    end
  endtask

  task automatic step(input logic [11:0] xx, input logic [11:0] yy, input logic dd,
                      input logic [23:0] l, input logic [23:0] r);
    x = xx; y = yy; de = dd;
    cyc_step(dd, l, r);
  endtask

  task automatic idle();
    step(12'd0, 12'd0, 1'b0, 24'h0, 24'h0);
  endtask

  task automatic wr_cell(input logic [12:0] a, input logic [14:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    idle();
    wr_en = 1'b0;
  endtask

  task automatic pal_wr(input logic [3:0] i, input logic [23:0] d);
    pal_wr_en = 1'b1; pal_idx = i; pal_data = d;
    idle();
    pal_wr_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    resetn = 1'b1; x = '0; y = '0; de = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    pal_wr_en = 1'b0; pal_idx = '0; pal_data = '0;
    cur_en = 1'b0; cur_col = '0; cur_row = '0;
    #1 resetn = 1'b0;
    #2;
    chk("rst_color", 48'(color_l), 48'h0);
    chk("rst_color_even", 48'(color_r), 48'h0);
    chk("rst_de", 48'(de_out), 48'h0);
    chk("rst_font_addr", 48'(font_addr), 48'h0);
    @(posedge clk);
    @(posedge clk);
    #1 resetn = 1'b1;
    cyc = 0;

    wr_cell(13'd0,   {4'hF, 4'h0, 7'h41});
    wr_cell(13'd1,   {4'hF, 4'h3, 7'h42});
    wr_cell(13'd120, {4'hF, 4'h0, 7'h55});
    pal_wr(4'd3, 24'h00FF00);

    // Glyph 0x81 across cell 0, then all-background cell 1
    step(12'd0, 12'd0, 1'b1, 24'hFFFFFF, 24'h000000);
    step(12'd1, 12'd0, 1'b1, 24'h000000, 24'h000000);
    chk("font_addr_x0", 48'(font_addr), 48'h410);
    step(12'd2, 12'd0, 1'b1, 24'h000000, 24'h000000);
    step(12'd3, 12'd0, 1'b1, 24'h000000, 24'hFFFFFF);
    step(12'd4, 12'd0, 1'b1, 24'h00FF00, 24'h00FF00);
    step(12'd5, 12'd0, 1'b1, 24'h00FF00, 24'h00FF00);
    chk("font_addr_x4", 48'(font_addr), 48'h420);
    step(12'd6, 12'd0, 1'b1, 24'h00FF00, 24'h00FF00);
    step(12'd7, 12'd0, 1'b1, 24'h00FF00, 24'h00FF00);

    // Vertical scale: y=2,3 both use glyph row 1; y=32 is cell row 1 (cell 120)
    step(12'd0, 12'd2, 1'b1, 24'h000000, 24'hFFFFFF);
    step(12'd1, 12'd3, 1'b1, 24'hFFFFFF, 24'h000000);
    chk("font_addr_y2", 48'(font_addr), 48'h411);
    step(12'd0, 12'd32, 1'b1, 24'hFFFFFF, 24'hFFFFFF);
    chk("font_addr_y3", 48'(font_addr), 48'h411);
    idle();
    chk("font_addr_y32", 48'(font_addr), 48'h550);
    idle(); idle();

    // Border on column and row limits, then de=0
    pal_wr(4'd0, 24'h123456);
    step(12'd480, 12'd0,    1'b1, 24'h123456, 24'h123456);
    step(12'd600, 12'd10,   1'b1, 24'h123456, 24'h123456);
    step(12'd0,   12'd1184, 1'b1, 24'h123456, 24'h123456);
    step(12'd0,   12'd0,    1'b0, 24'h000000, 24'h000000);
    step(12'd480, 12'd0,    1'b0, 24'h000000, 24'h000000);
    pal_wr(4'd0, 24'h000000);

    // Cursor on cell 0: phase is the blink counter MSB at the sampling edge
    cur_en = 1'b1; cur_col = 7'd0; cur_row = 6'd0;
    for (int i = 0; i < 32; i++) begin
      if (cyc[3]) step(12'd0, 12'd0, 1'b1, 24'h000000, 24'hFFFFFF);
      else        step(12'd0, 12'd0, 1'b1, 24'hFFFFFF, 24'h000000);
    end
    cur_en = 1'b0;
    for (int i = 0; i < 16; i++) step(12'd0, 12'd0, 1'b1, 24'hFFFFFF, 24'h000000);
    idle(); idle(); idle();

    // Out-of-range write must not disturb any cell
    wr_cell(13'd4440, {4'h3, 4'hF, 7'h43});
    step(12'd0, 12'd0,  1'b1, 24'hFFFFFF, 24'h000000);
    step(12'd4, 12'd0,  1'b1, 24'h00FF00, 24'h00FF00);
    step(12'd0, 12'd32, 1'b1, 24'hFFFFFF, 24'hFFFFFF);
    step(12'd3, 12'd0,  1'b1, 24'h000000, 24'hFFFFFF);
    step(12'd3, 12'd0,  1'b1, 24'h000000, 24'hFFFFFF);
    step(12'd3, 12'd0,  1'b1, 24'h000000, 24'hFFFFFF);

    // Mid-line asynchronous reset with pixels in flight
    #2 resetn = 1'b0;
    #1;
    chk("midrst_color", 48'(color_l), 48'h0);
    chk("midrst_color_even", 48'(color_r), 48'h0);
    chk("midrst_de", 48'(de_out), 48'h0);
    chk("midrst_font_addr", 48'(font_addr), 48'h0);
    exp_q.delete();
    de = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 resetn = 1'b1;
    cyc = 0;
    idle(); idle();
    step(12'd0, 12'd0, 1'b1, 24'hFFFFFF, 24'h000000);
    step(12'd4, 12'd0, 1'b1, 24'h000000, 24'h000000);
    idle(); idle(); idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
